// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the instruction/data memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int STARVE_W = 4;
    localparam int STALL_W  = 16;

    // Which port owns the read data returning from memory this cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IM   = 2'd1,
        OWN_DM   = 2'd2
    } owner_e;

endpackage

// File: rtl/arb_prio.sv
// Fixed data-priority arbitration with an instruction anti-starvation override.
import mem_arb_pkg::*;

module arb_prio #(
    parameter int STARVE_MAX = 4
) (
    input  logic                im_req,
    input  logic                dm_req,
    input  logic [STARVE_W-1:0] starve_cnt,
    output logic                im_gnt,
    output logic                dm_gnt
);

    logic im_forced;

    assign im_forced = (starve_cnt == STARVE_W'(STARVE_MAX));

    // Data wins contention unless instruction has waited STARVE_MAX data grants.
    always_comb begin
        im_gnt = im_req && (!dm_req || im_forced);
        dm_gnt = dm_req && !im_gnt;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of one shared
// single-cycle-latency memory.
//
// Handshake: a request is accepted in the cycle where req and gnt are both
// high; gnt is combinational from req and registered arbitration state, and
// the requester must hold req/address/data stable until it sees gnt. Read
// data returns with a one-cycle rvalid pulse the cycle after the grant; there
// is no backpressure on the response.
import mem_arb_pkg::*;

module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               im_req_i,
    input  logic [ADDR_W-1:0]  im_addr_i,
    output logic               im_gnt_o,
    output logic               im_rvalid_o,
    output logic [DATA_W-1:0]  im_rdata_o,
    input  logic               dm_req_i,
    input  logic               dm_wen_i,
    input  logic [ADDR_W-1:0]  dm_addr_i,
    input  logic [DATA_W-1:0]  dm_wdata_i,
    output logic               dm_gnt_o,
    output logic               dm_rvalid_o,
    output logic [DATA_W-1:0]  dm_rdata_o,
    output logic               mem_wen_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    output logic [DATA_W-1:0]  mem_din_o,
    input  logic [DATA_W-1:0]  mem_dout_i,
    output logic [STALL_W-1:0] im_stall_cnt_o
);

    logic                im_req_act;
    logic                dm_req_act;
    logic                im_gnt;
    logic                dm_gnt;
    logic [STARVE_W-1:0] starve_cnt;
    owner_e              owner_q;
    logic [STALL_W-1:0]  stall_cnt;

    // Requests are masked while reset is held so nothing is granted.
    assign im_req_act = im_req_i & rst_n_i;
    assign dm_req_act = dm_req_i & rst_n_i;

    arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb_prio (
        .im_req     (im_req_act),
        .dm_req     (dm_req_act),
        .starve_cnt (starve_cnt),
        .im_gnt     (im_gnt),
        .dm_gnt     (dm_gnt)
    );

    assign im_gnt_o = im_gnt;
    assign dm_gnt_o = dm_gnt;

    // Memory port mux: the granted request drives the memory, idle drives zeros.
    always_comb begin
        mem_wen_o  = 1'b0;
        mem_addr_o = '0;
        mem_din_o  = '0;
        if (im_gnt) begin
            mem_addr_o = im_addr_i;
            mem_din_o  = dm_wdata_i;
        end else if (dm_gnt) begin
            mem_wen_o  = dm_wen_i;
            mem_addr_o = dm_addr_i;
            mem_din_o  = dm_wdata_i;
        end
    end

    // Count consecutive data grants taken while a fetch is waiting.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            starve_cnt <= '0;
        end else if (!im_req_i || im_gnt) begin
            starve_cnt <= '0;
        end else if (dm_gnt) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Remember who gets the read data next cycle; writes return nothing.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            owner_q <= OWN_NONE;
        end else if (im_gnt) begin
            owner_q <= OWN_IM;
        end else if (dm_gnt && !dm_wen_i) begin
            owner_q <= OWN_DM;
        end else begin
            owner_q <= OWN_NONE;
        end
    end

    // Route returning memory data to its owner only; the other port sees zero.
    always_comb begin
        im_rvalid_o = (owner_q == OWN_IM);
        dm_rvalid_o = (owner_q == OWN_DM);
        im_rdata_o  = im_rvalid_o ? mem_dout_i : '0;
        dm_rdata_o  = dm_rvalid_o ? mem_dout_i : '0;
    end

    // Saturating count of cycles a fetch request sat ungranted.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt <= '0;
        end else if (im_req_i && !im_gnt && (stall_cnt != {STALL_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign im_stall_cnt_o = stall_cnt;

endmodule
